aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller.
- Owns the 128-bit state register and round-key register, and generates Rcon.
- Steps an external combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus one key-expansion step) once per clock.
- Sits between a valid/ready block source and a valid/ready ciphertext sink; the initial whitening AddRoundKey is applied at load.

Parameters:
- NR, 10, number of rounds after initial key addition; final round skips MixColumns.
- RW, 4, width of round counter; must satisfy 2^RW > NR.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext+key offered.
- in_ready  out  1  sequencer can accept a block.
- in_text  in  128  plaintext, word w0 in bits [127:96].
- in_key  in  128  cipher key, word k0 in bits [127:96].
- out_valid  out  1  ciphertext available.
- out_ready  in  1  sink accepts ciphertext.
- out_text  out  128  ciphertext (= state register).
- abort  in  1  synchronous abandon of current block.
- dp_state  out  128  current state to datapath.
- dp_key  out  128  current round key to datapath.
- dp_rcon  out  8  Rcon for this key-expansion step.
- dp_final  out  1  high when round_idx == NR; datapath bypasses MixColumns.
- dp_state_next  in  128  datapath result of round using dp_key_next.
- dp_key_next  in  128  next round key from dp_key and dp_rcon.
- round_idx  out  RW  current round number, 0 when idle.
- busy  out  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM = IDLE; state_q, key_q, out_text = 0; round_idx = 0; rcon_q = 8'h01.
  - out_valid = 0, busy = 0, in_ready = 1 once reset releases.
- FSM states: IDLE, RUN, DONE.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready); combinational, no dependency on in_valid.
- Accept = in_valid & in_ready at a rising edge:
  - state_q <= in_text ^ in_key; key_q <= in_key.
  - round_idx <= 1; rcon_q <= 8'h01; FSM <= RUN.
- RUN, each edge:
  - state_q <= dp_state_next; key_q <= dp_key_next.
  - rcon_q <= xtime(rcon_q) = {rcon_q[6:0],1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00).
  - If round_idx == NR: FSM <= DONE, round_idx <= 0; else round_idx <= round_idx + 1.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- dp_rcon = rcon_q; dp_final = (FSM==RUN) & (round_idx==NR).
- Latency: out_valid rises exactly NR+1 edges after the accept edge (one load plus NR rounds). Throughput is one block per NR+1 cycles with back-to-back accept.
- DONE:
  - out_valid = 1; out_text stable while out_valid & ~out_ready.
  - out_ready high: handshake completes. If in_valid is also high the same edge performs an accept (→RUN), else → IDLE.
- IDLE/DONE: state_q, key_q hold; dp_* outputs remain driven but are ignored.
- abort (sync, highest priority after reset):
  - Any state → IDLE at next edge; round_idx <= 0; rcon_q <= 01; out_valid drops.
  - Registers are not cleared.
  - abort with in_valid in IDLE: no accept (in_ready forced low while abort is high).
- Reset asserted mid-RUN: immediate return to reset values; the partial block is lost and not emitted.
- in_text/in_key are sampled only at accept; changes during RUN have no effect.

Test Plan:
- FIPS-197 App. B with the real round datapath: in_text=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_valid 11 edges after accept, out_text=3925841d02dc09fbdc118597196a0b32, dp_rcon sequence 01..36, dp_final high only in round 10.
- FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: out_ready=0 for 5 cycles after done -> out_valid held, out_text unchanged, in_ready=0; out_ready=1 -> transfer in one cycle, then IDLE.
- Back-to-back: two App. B blocks with in_valid and out_ready held high -> second accept on the same edge as first output handshake, second out_valid 11 edges later, no idle cycle.
- abort at round 5 -> FSM IDLE next edge, out_valid never asserts, next block (App. C.1) produces correct ciphertext with Rcon restarting at 01.
- rst_n pulsed low mid-RUN (asynchronous, between edges) -> out_valid=0, round_idx=0, busy=0 immediately; after release in_ready=1 and a fresh App. B block passes.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer: owns the state, round-key and Rcon registers
// and steps an external combinational round datapath once per clock.
module aes_round_sequencer #(
   parameter int NR = 10,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  in_text,
   input  logic [127:0]  in_key,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_text,
   input  logic          abort,
   output logic [127:0]  dp_state,
   output logic [127:0]  dp_key,
   output logic [7:0]    dp_rcon,
   output logic          dp_final,
   input  logic [127:0]  dp_state_next,
   input  logic [127:0]  dp_key_next,
   output logic [RW-1:0] round_idx,
   output logic          busy
);

   // state | meaning
   // IDLE  | no block held, ready to accept
   // RUN   | one round per edge, round_q = round being computed
   // DONE  | ciphertext presented on out_text until out_ready

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   localparam logic [RW-1:0] NR_C = RW'(NR);

   fsm_t          fsm_q;
   fsm_t          fsm_d;
   logic [127:0]  state_q;
   logic [127:0]  key_q;
   logic [7:0]    rcon_q;
   logic [RW-1:0] round_q;
   logic          accept;
   logic          last_round;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   assign last_round = (round_q == NR_C);

   // abort masks in_ready so a block offered alongside abort is never taken
   assign in_ready = ~abort & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      if (abort) begin
         fsm_d = IDLE;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (accept) fsm_d = RUN;
            end
            RUN: begin
               if (last_round) fsm_d = DONE;
            end
            DONE: begin
               if (accept) begin
                  fsm_d = RUN;
               end else if (out_ready) begin
                  fsm_d = IDLE;
               end
            end
            default: fsm_d = IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid = 1'b0;
      busy      = 1'b0;
      dp_final  = 1'b0;
      case (fsm_q)
         RUN: begin
            busy     = 1'b1;
            dp_final = last_round;
         end
         DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   // Accept only happens in IDLE/DONE, so it never competes with a RUN update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         key_q   <= '0;
         rcon_q  <= 8'h01;
         round_q <= '0;
      end else if (abort) begin
         rcon_q  <= 8'h01;
         round_q <= '0;
      end else if (accept) begin
         state_q <= in_text ^ in_key;
         key_q   <= in_key;
         rcon_q  <= 8'h01;
         round_q <= RW'(1);
      end else if (fsm_q == RUN) begin
         state_q <= dp_state_next;
         key_q   <= dp_key_next;
         rcon_q  <= xtime(rcon_q);
         round_q <= last_round ? '0 : round_q + RW'(1);
      end
   end

   assign out_text  = state_q;
   assign dp_state  = state_q;
   assign dp_key    = key_q;
   assign dp_rcon   = rcon_q;
   assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES-128 round datapath plus a
// scoreboard fed from a whole-block AES reference model and FIPS-197 vectors.
module tb_aes_round_sequencer;
   localparam int NR = 10;
   localparam int RW = 4;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  in_text = '0;
   logic [127:0]  in_key = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [127:0]  out_text;
   logic          abort = 1'b0;
   logic [127:0]  dp_state;
   logic [127:0]  dp_key;
   logic [7:0]    dp_rcon;
   logic          dp_final;
   logic [127:0]  dp_state_next;
   logic [127:0]  dp_key_next;
   logic [RW-1:0] round_idx;
   logic          busy;

   int n_checks = 0;
   int n_pass = 0;
   logic [127:0] exp_q[$];
   logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   always #5 clk = ~clk;

   aes_round_sequencer #(.NR(NR), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
      .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
      .abort(abort),
      .dp_state(dp_state), .dp_key(dp_key), .dp_rcon(dp_rcon), .dp_final(dp_final),
      .dp_state_next(dp_state_next), .dp_key_next(dp_key_next),
      .round_idx(round_idx), .busy(busy)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                              input logic fin);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      if (!fin) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
         end
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
      return res ^ rk;
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] st;
      logic [127:0] k;
      st = pt ^ key;
      k = key;
      for (int r = 1; r <= NR; r++) begin
         k = key_step(k, rcon_tab[r-1]);
         st = aes_round(st, k, r == NR);
      end
      return st;
   endfunction

   assign dp_key_next   = key_step(dp_key, dp_rcon);
   assign dp_state_next = aes_round(dp_state, dp_key_next, dp_final);

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got %h, expected no output", out_text);
         end else begin
            check("out_text", out_text, exp_q.pop_front());
         end
      end
   end

   // Offers a block until accepted; returns at posedge+1 of the accept edge.
   task automatic accept_block(input logic [127:0] pt, input logic [127:0] key,
                               input logic [127:0] exp, input bit push);
      bit ok;
      ok = 1'b0;
      in_text = pt;
      in_key = key;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) exp_q.push_back(exp);
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      // inputs are only sampled at accept, so garbage here must not matter
      in_text = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (!ok) begin
         n_checks++;
         $display("FAIL accept_timeout: got no accept, expected accept within 100 cycles");
      end
   endtask

   // Follows the NR rounds after an accept; ends on the negedge where out_valid
   // must first be visible, i.e. NR+1 edges counting the accept edge.
   task automatic trace_run();
      for (int r = 1; r <= NR; r++) begin
         @(negedge clk);
         check("round_idx", 128'(round_idx), 128'(r));
         check("dp_rcon", 128'(dp_rcon), 128'(rcon_tab[r-1]));
         check("dp_final", 128'(dp_final), 128'(r == NR));
         check("busy_run", 128'(busy), 128'(1));
         check("out_valid_early", 128'(out_valid), 128'(0));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("latency_out_valid", 128'(out_valid), 128'(1));
      check("done_round_idx", 128'(round_idx), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a1, a2, first_ov, acc, ov_cnt;
      logic ov2;
      logic [127:0] pt, key, snap;
      bit hs;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_round_idx", 128'(round_idx), 128'(0));
      check("rst_out_text", out_text, 128'(0));
      check("rst_dp_key", dp_key, 128'(0));
      check("rst_dp_rcon", 128'(dp_rcon), 128'(8'h01));
      @(posedge clk);
      #1;

      // FIPS-197 App. B and App. C.1
      out_ready = 1'b1;
      accept_block(PT_B, KEY_B, CT_B, 1'b1);
      trace_run();
      @(posedge clk);
      #1;
      @(negedge clk);
      check("idle_after_b", 128'(out_valid), 128'(0));
      check("idle_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      accept_block(PT_C, KEY_C, CT_C, 1'b1);
      trace_run();
      @(posedge clk);
      #1;

      // backpressure for 5 cycles
      out_ready = 1'b0;
      accept_block(PT_B, KEY_B, CT_B, 1'b1);
      trace_run();
      snap = CT_B;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_out_text", out_text, snap);
         check("bp_in_ready", 128'(in_ready), 128'(0));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_idle_out_valid", 128'(out_valid), 128'(0));
      check("bp_idle_busy", 128'(busy), 128'(0));
      @(posedge clk);
      #1;

      // back-to-back blocks
      a1 = -1; a2 = -1; first_ov = -1; acc = 0; ov2 = 1'b0;
      in_text = PT_B;
      in_key = KEY_B;
      in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (acc == 2 && out_valid && first_ov < 0) first_ov = i;
         if (in_valid && in_ready) begin
            if (acc == 0) a1 = i;
            else begin
               a2 = i;
               ov2 = out_valid;
            end
            acc++;
            exp_q.push_back(CT_B);
         end
         @(posedge clk);
         #1;
         if (acc == 2) in_valid = 1'b0;
         if (first_ov >= 0) break;
      end
      in_valid = 1'b0;
      check("b2b_accept_spacing", 128'(a2 - a1), 128'(NR + 1));
      check("b2b_accept_on_handshake", 128'(ov2), 128'(1));
      check("b2b_second_latency", 128'(first_ov - a2), 128'(NR + 1));

      // abort at round 5, then App. C.1
      accept_block(PT_B, KEY_B, CT_B, 1'b0);
      repeat (4) begin
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("abort_round_idx", 128'(round_idx), 128'(5));
      abort = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_round_idx0", 128'(round_idx), 128'(0));
      check("abort_rcon", 128'(dp_rcon), 128'(8'h01));
      check("abort_out_valid", 128'(out_valid), 128'(0));
      check("abort_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      check("abort_no_accept", 128'(busy), 128'(0));
      abort = 1'b0;
      in_valid = 1'b0;
      ov_cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) ov_cnt++;
         @(posedge clk);
         #1;
      end
      check("abort_never_valid", 128'(ov_cnt), 128'(0));
      accept_block(PT_C, KEY_C, CT_C, 1'b1);
      trace_run();
      @(posedge clk);
      #1;

      // asynchronous reset mid-RUN
      accept_block(PT_B, KEY_B, CT_B, 1'b0);
      repeat (3) begin
         @(negedge clk);
         @(posedge clk);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 128'(out_valid), 128'(0));
      check("arst_round_idx", 128'(round_idx), 128'(0));
      check("arst_busy", 128'(busy), 128'(0));
      check("arst_out_text", out_text, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("arst_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      accept_block(PT_B, KEY_B, CT_B, 1'b1);
      trace_run();
      @(posedge clk);
      #1;

      // random blocks with random sink backpressure
      repeat (6) begin
         pt = {$urandom(), $urandom(), $urandom(), $urandom()};
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         out_ready = 1'($urandom_range(0, 1));
         accept_block(pt, key, aes_encrypt(pt, key), 1'b1);
         trace_run();
         hs = 1'b0;
         for (int i = 0; i < 30; i++) begin
            if (out_ready) hs = 1'b1;
            @(posedge clk);
            #1;
            if (hs) break;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         check("rand_handshake", 128'(hs), 128'(1));
      end

      @(negedge clk);
      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
